// File: rtl/ram_stream_loader.sv
// rtl/ram_stream_loader.sv - stream-to-RAM writer with base/length, modulo wrap and registered read port
module ram_stream_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    last_word;

    // Gated by rst_n so a transfer offered in the reset cycle is not committed.
    assign wr_en     = s_valid && s_ready && rst_n;
    assign wr_addr   = base_q + wr_count[ADDR_WIDTH-1:0];
    assign last_word = ((wr_count + 1'b1) == len_q);

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = (len == '0) ? DONE : WRITE;
            end
            WRITE: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid && last_word)
                    state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            wr_count <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                base_q   <= base_addr;
                len_q    <= len;
                wr_count <= '0;
            end else if (wr_en) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

    // RAM contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= s_data;
    end

    // Read-first: a same-address write in this cycle is not visible until the next read.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end
endmodule
